// File: rtl/friscv_test_sequencer.sv
// friscv_test_sequencer: run controller for friscv regression and bring-up.
// Holds the core in reset, runs it until ebreak, timeout or tohost, drains, then grades.
//
// Ports:
//   aclk, aresetn, srst      clock, async active-low reset, sync active-high reset
//   start                    run launch pulse (honoured in IDLE and DONE)
//   ebreak                   core halt indication
//   mem_en/wr/addr/wdata/ready  snooped core data-memory port (tohost only)
//   err_count                core error register, sampled at grading
//   core_rstn, core_enable   core reset (active low) and enable
//   busy, done, pass, timed_out, exit_code, cycles   run status and results
//
// Optional feature: define FRISCV_TOHOST_EN to enable the memory-mapped tohost stop.

module friscv_test_sequencer #(
    parameter int DATA_ADDRW   = 16,
    parameter int XLEN         = 32,
    parameter int RST_CYCLES   = 5,
    parameter int TIMEOUT      = 100,
    parameter int DRAIN_CYCLES = 5,
    parameter int CNTW         = 32,
    parameter int TOHOST_ADDR  = 'hFFF0
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  srst,
    input  logic                  start,
    input  logic                  ebreak,
    input  logic                  mem_en,
    input  logic                  mem_wr,
    input  logic [DATA_ADDRW-1:0] mem_addr,
    input  logic [XLEN-1:0]       mem_wdata,
    input  logic                  mem_ready,
    input  logic [XLEN-1:0]       err_count,
    output logic                  core_rstn,
    output logic                  core_enable,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timed_out,
    output logic [XLEN-2:0]       exit_code,
    output logic [CNTW-1:0]       cycles
);

    typedef enum logic [2:0] {
        IDLE,
        RST,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [DATA_ADDRW-1:0] TOHOST_A = DATA_ADDRW'(TOHOST_ADDR);
    localparam logic [CNTW-1:0]       TO_VAL   = CNTW'(TIMEOUT);

    state_t          state;
    logic [31:0]     cnt;
    logic [CNTW-1:0] cycles_nxt;
    logic            hit;
    logic [XLEN-2:0] hit_code;
    logic            to_hit;
    logic            stop;
    logic            stop_to;
    logic [XLEN-2:0] stop_code;

`ifdef FRISCV_TOHOST_EN
    assign hit = mem_en & mem_wr & mem_ready
               & (mem_addr == TOHOST_A) & mem_wdata[0];
    assign hit_code = mem_wdata[XLEN-1:1];
`else
    logic unused_mem;
    assign unused_mem = ^{mem_en, mem_wr, mem_ready, mem_addr, mem_wdata, TOHOST_A};
    assign hit = 1'b0;
    assign hit_code = '0;
`endif

    // Count including the current RUN cycle; saturates instead of wrapping.
    assign cycles_nxt = (&cycles) ? cycles : cycles + 1'b1;
    assign to_hit     = (TIMEOUT != 0) && (cycles_nxt == TO_VAL);
    assign stop       = ebreak | hit | to_hit;
    // ebreak or tohost in the same cycle take precedence over the timeout.
    assign stop_to    = to_hit & ~ebreak & ~hit;
    assign stop_code  = hit ? hit_code : '0;

    function automatic logic grade(input logic [XLEN-1:0] e,
                                   input logic            t,
                                   input logic [XLEN-2:0] c);
        return (e == '0) && !t && (c == '0);
    endfunction

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= IDLE;
            cnt         <= '0;
            core_rstn   <= 1'b0;
            core_enable <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timed_out   <= 1'b0;
            exit_code   <= '0;
            cycles      <= '0;
        end else if (srst) begin
            state       <= IDLE;
            cnt         <= '0;
            core_rstn   <= 1'b0;
            core_enable <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timed_out   <= 1'b0;
            exit_code   <= '0;
            cycles      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= RST;
                        cnt         <= '0;
                        cycles      <= '0;
                        pass        <= 1'b0;
                        timed_out   <= 1'b0;
                        exit_code   <= '0;
                        done        <= 1'b0;
                        busy        <= 1'b1;
                        core_rstn   <= 1'b0;
                        core_enable <= 1'b0;
                    end
                end
                RST: begin
                    // Release lands RST_CYCLES+1 edges after the start edge.
                    if (cnt == 32'(RST_CYCLES)) begin
                        state       <= RUN;
                        core_rstn   <= 1'b1;
                        core_enable <= 1'b1;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                RUN: begin
                    cycles <= cycles_nxt;
                    if (stop) begin
                        core_enable <= 1'b0;
                        timed_out   <= stop_to;
                        exit_code   <= stop_code;
                        cnt         <= '0;
                        if (DRAIN_CYCLES == 0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= grade(err_count, stop_to, stop_code);
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt == 32'(DRAIN_CYCLES - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= grade(err_count, timed_out, exit_code);
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_friscv_test_sequencer.sv
// tb_friscv_test_sequencer: directed bench for friscv_test_sequencer.
// Default instance plus a CNTW=4, TIMEOUT=0 instance for saturation.

module tb_friscv_test_sequencer;

    logic        clk = 1'b0;
    logic        aresetn, srst, start, ebreak;
    logic        mem_en, mem_wr, mem_ready;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, err_count;
    logic        core_rstn, core_enable, busy, done, pass, timed_out;
    logic [30:0] exit_code;
    logic [31:0] cycles;

    logic        start2, ebreak2;
    logic        core_rstn2, core_enable2, busy2, done2, pass2, timed_out2;
    logic [30:0] exit_code2;
    logic [3:0]  cycles2;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    friscv_test_sequencer dut (
        .aclk(clk), .aresetn(aresetn), .srst(srst), .start(start),
        .ebreak(ebreak), .mem_en(mem_en), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .err_count(err_count), .core_rstn(core_rstn),
        .core_enable(core_enable), .busy(busy), .done(done), .pass(pass),
        .timed_out(timed_out), .exit_code(exit_code), .cycles(cycles)
    );

    friscv_test_sequencer #(.CNTW(4), .TIMEOUT(0)) dut2 (
        .aclk(clk), .aresetn(aresetn), .srst(srst), .start(start2),
        .ebreak(ebreak2), .mem_en(1'b0), .mem_wr(1'b0),
        .mem_addr(16'h0), .mem_wdata(32'h0), .mem_ready(1'b0),
        .err_count(32'h0), .core_rstn(core_rstn2),
        .core_enable(core_enable2), .busy(busy2), .done(done2),
        .pass(pass2), .timed_out(timed_out2), .exit_code(exit_code2),
        .cycles(cycles2)
    );

    task automatic launch(output int lat);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!core_rstn && lat < 50);
    endtask

    // Assert ebreak during RUN cycle k, counting the current cycle as 1.
    task automatic run_ebreak(input int k);
        repeat (k - 1) @(posedge clk);
        #1 ebreak = 1'b1;
        @(posedge clk); #1 ebreak = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({core_rstn, core_enable, busy, done, pass, timed_out} !== 6'b0)
            $display("FAIL reset_flags got %b want 000000",
                     {core_rstn, core_enable, busy, done, pass, timed_out});
        else passed++;
        checks++;
        if (cycles !== 32'd0 || exit_code !== 31'd0)
            $display("FAIL reset_counts got cycles=%0d code=%0d want 0 0",
                     cycles, exit_code);
        else passed++;
        #10 aresetn = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || core_rstn !== 1'b0)
            $display("FAIL idle_hold got busy=%b rstn=%b want 0 0",
                     busy, core_rstn);
        else passed++;
    endtask

    task automatic test_ebreak;
        int lat, n;
        launch(lat);
        checks++;
        if (lat !== 6) $display("FAIL rst_latency got %0d want 6", lat);
        else passed++;
        checks++;
        if (core_enable !== 1'b1 || busy !== 1'b1)
            $display("FAIL run_enable got en=%b busy=%b want 1 1",
                     core_enable, busy);
        else passed++;
        run_ebreak(40);
        checks++;
        if (cycles !== 32'd40) $display("FAIL ebreak_cycles got %0d want 40", cycles);
        else passed++;
        checks++;
        if ({core_enable, core_rstn, busy, done} !== 4'b0110)
            $display("FAIL drain_flags got %b want 0110",
                     {core_enable, core_rstn, busy, done});
        else passed++;
        wait_done(n);
        checks++;
        if (n !== 5) $display("FAIL drain_len got %0d want 5", n);
        else passed++;
        checks++;
        if ({pass, timed_out, busy} !== 3'b100 || exit_code !== 31'd0)
            $display("FAIL ebreak_grade got pass=%b to=%b busy=%b want 1 0 0",
                     pass, timed_out, busy);
        else passed++;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({done, pass, core_rstn, core_enable} !== 4'b1110 || cycles !== 32'd40)
            $display("FAIL done_hold got %b cyc=%0d want 1110 40",
                     {done, pass, core_rstn, core_enable}, cycles);
        else passed++;
    endtask

    task automatic test_timeout;
        int lat, n;
        launch(lat);
        wait_done(n);
        checks++;
        if (n !== 105) $display("FAIL timeout_len got %0d want 105", n);
        else passed++;
        checks++;
        if (cycles !== 32'd100 || timed_out !== 1'b1 || pass !== 1'b0)
            $display("FAIL timeout_grade got cyc=%0d to=%b pass=%b want 100 1 0",
                     cycles, timed_out, pass);
        else passed++;
    endtask

    task automatic test_both;
        int lat, n;
        launch(lat);
        run_ebreak(100);
        wait_done(n);
        checks++;
        if (cycles !== 32'd100 || timed_out !== 1'b0 || pass !== 1'b1)
            $display("FAIL both_grade got cyc=%0d to=%b pass=%b want 100 0 1",
                     cycles, timed_out, pass);
        else passed++;
    endtask

    task automatic test_err;
        int lat, n;
        err_count = 32'd3;
        launch(lat);
        run_ebreak(10);
        wait_done(n);
        checks++;
        if ({done, pass, timed_out} !== 3'b100 || exit_code !== 31'd0)
            $display("FAIL err_grade got done=%b pass=%b to=%b code=%0d want 1 0 0 0",
                     done, pass, timed_out, exit_code);
        else passed++;
        err_count = 32'd0;
    endtask

    task automatic test_start_ignored;
        int lat, n;
        launch(lat);
        start = 1'b1;
        run_ebreak(20);
        start = 1'b0;
        checks++;
        if (cycles !== 32'd20 || busy !== 1'b1)
            $display("FAIL start_run got cyc=%0d busy=%b want 20 1", cycles, busy);
        else passed++;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(n);
        checks++;
        if (n !== 4 || cycles !== 32'd20 || pass !== 1'b1)
            $display("FAIL start_drain got n=%0d cyc=%0d pass=%b want 4 20 1",
                     n, cycles, pass);
        else passed++;
    endtask

    task automatic test_reset_midrun;
        int lat, n;
        launch(lat);
        repeat (10) @(posedge clk);
        #2 aresetn = 1'b0;
        #1;
        checks++;
        if ({core_rstn, core_enable, busy, done} !== 4'b0 || cycles !== 32'd0)
            $display("FAIL midrun_reset got %b cyc=%0d want 0000 0",
                     {core_rstn, core_enable, busy, done}, cycles);
        else passed++;
        aresetn = 1'b1;
        launch(lat);
        checks++;
        if (lat !== 6) $display("FAIL rerun_latency got %0d want 6", lat);
        else passed++;
        run_ebreak(7);
        wait_done(n);
        checks++;
        if (n !== 5 || cycles !== 32'd7 || pass !== 1'b1 || timed_out !== 1'b0)
            $display("FAIL rerun_grade got n=%0d cyc=%0d pass=%b to=%b want 5 7 1 0",
                     n, cycles, pass, timed_out);
        else passed++;
    endtask

    task automatic test_srst;
        int lat;
        launch(lat);
        repeat (3) @(posedge clk);
        #1 srst = 1'b1;
        @(posedge clk); #1 srst = 1'b0;
        checks++;
        if ({core_rstn, core_enable, busy, done, pass} !== 5'b0 || cycles !== 32'd0)
            $display("FAIL srst got %b cyc=%0d want 00000 0",
                     {core_rstn, core_enable, busy, done, pass}, cycles);
        else passed++;
    endtask

    task automatic test_saturate;
        int n;
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        n = 0;
        while (!core_rstn2 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (29) @(posedge clk);
        #1 ebreak2 = 1'b1;
        @(posedge clk); #1 ebreak2 = 1'b0;
        n = 0;
        while (!done2 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (cycles2 !== 4'd15 || pass2 !== 1'b1 || done2 !== 1'b1 || timed_out2 !== 1'b0)
            $display("FAIL saturate got cyc=%0d pass=%b done=%b to=%b want 15 1 1 0",
                     cycles2, pass2, done2, timed_out2);
        else passed++;
    endtask

`ifdef FRISCV_TOHOST_EN
    task automatic tohost_write(input logic [31:0] d);
        #1;
        mem_en = 1'b1; mem_wr = 1'b1; mem_ready = 1'b1;
        mem_addr = 16'hFFF0; mem_wdata = d;
        @(posedge clk); #1;
        mem_en = 1'b0; mem_wr = 1'b0; mem_ready = 1'b0;
        mem_addr = 16'h0; mem_wdata = 32'h0;
    endtask

    task automatic test_tohost;
        int lat, n;
        launch(lat);
        repeat (4) @(posedge clk);
        tohost_write(32'h7);
        checks++;
        if (cycles !== 32'd5 || core_enable !== 1'b0)
            $display("FAIL tohost7_stop got cyc=%0d en=%b want 5 0", cycles, core_enable);
        else passed++;
        wait_done(n);
        checks++;
        if (exit_code !== 31'd3 || pass !== 1'b0 || timed_out !== 1'b0)
            $display("FAIL tohost7_grade got code=%0d pass=%b want 3 0", exit_code, pass);
        else passed++;
        launch(lat);
        repeat (2) @(posedge clk);
        tohost_write(32'h6);
        checks++;
        if (core_enable !== 1'b1 || busy !== 1'b1)
            $display("FAIL tohost6_nostop got en=%b busy=%b want 1 1", core_enable, busy);
        else passed++;
        run_ebreak(5);
        wait_done(n);
        checks++;
        if (cycles !== 32'd8 || exit_code !== 31'd0 || pass !== 1'b1)
            $display("FAIL tohost6_grade got cyc=%0d code=%0d pass=%b want 8 0 1",
                     cycles, exit_code, pass);
        else passed++;
        launch(lat);
        tohost_write(32'h1);
        wait_done(n);
        checks++;
        if (cycles !== 32'd1 || exit_code !== 31'd0 || pass !== 1'b1)
            $display("FAIL tohost1_grade got cyc=%0d code=%0d pass=%b want 1 0 1",
                     cycles, exit_code, pass);
        else passed++;
    endtask
`endif

    initial begin
        aresetn = 1'b0; srst = 1'b0; start = 1'b0; ebreak = 1'b0;
        mem_en = 1'b0; mem_wr = 1'b0; mem_ready = 1'b0;
        mem_addr = 16'h0; mem_wdata = 32'h0; err_count = 32'h0;
        start2 = 1'b0; ebreak2 = 1'b0;
        test_reset();
        test_ebreak();
        test_timeout();
        test_both();
        test_err();
        test_start_ignored();
        test_reset_midrun();
        test_srst();
        test_saturate();
`ifdef FRISCV_TOHOST_EN
        test_tohost();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
